// File: rtl/rtc_ui_pkg.sv
// rtl/rtc_ui_pkg.sv - shared indices, button sequencer states and sizing helpers for the RTC input front end
package rtc_ui_pkg;

   localparam int NUM_BTN = 4;
   localparam int NUM_SW  = 5;

   // Button bit positions inside btn_raw / btn_pulse / btn_held
   localparam int BTN_UP  = 0;
   localparam int BTN_DWN = 1;
   localparam int BTN_LF  = 2;
   localparam int BTN_RG  = 3;

   // Switch bit positions inside sw_raw / sw_level / sw_rise / sw_fall
   localparam int SW_HORA  = 0;
   localparam int SW_FECHA = 1;
   localparam int SW_CRONO = 2;
   localparam int SW_INIC  = 3;
   localparam int SW_FMT   = 4;

   // Press / auto-repeat sequencer states of one button
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } btn_state_t;

   // Bits needed to hold the values 0..value; never narrower than one bit
   function automatic int cnt_width(input int value);
      return (value < 1) ? 1 : $clog2(value + 1);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/debounce_cell.sv
// rtl/debounce_cell.sv - two-flop synchroniser, debounce counter, accepted level and edge indications for one input
module debounce_cell
   import rtc_ui_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_a;
   logic          sync_b;
   logic [CW-1:0] cnt;
   logic          level_d;

   // Bring the asynchronous pin into the clock domain
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
      end
   end

   // Accept a new level only after it has disagreed with the current one for DEBOUNCE_CYCLES cycles in a row
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         level   <= 1'b0;
         level_d <= 1'b0;
      end else begin
         level_d <= level;
         if (sync_b == level) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            level <= sync_b;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   // Edge indications are valid during the first cycle the new accepted level is visible
   assign rise = level & ~level_d;
   assign fall = ~level & level_d;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced buttons with press/auto-repeat pulses and debounced switches with edge strobes
module button_conditioner
   import rtc_ui_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_DELAY    = 50_000_000,
   parameter int REPEAT_RATE     = 10_000_000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_BTN-1:0]  btn_raw,
   input  logic [NUM_SW-1:0]   sw_raw,
   output logic [NUM_BTN-1:0]  btn_pulse,
   output logic [NUM_BTN-1:0]  btn_held,
   output logic [NUM_SW-1:0]   sw_level,
   output logic [NUM_SW-1:0]   sw_rise,
   output logic [NUM_SW-1:0]   sw_fall
);

   // One shared down-counter per button covers both the initial delay and the repeat period
   localparam int            RW         = cnt_width(max_int(REPEAT_DELAY, REPEAT_RATE));
   localparam logic [RW-1:0] DELAY_LOAD = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RATE_LOAD  = RW'(REPEAT_RATE - 1);

   logic [NUM_BTN-1:0] btn_rise;
   logic [NUM_BTN-1:0] btn_fall;
   logic [NUM_SW-1:0]  sw_rise_c;
   logic [NUM_SW-1:0]  sw_fall_c;
   logic [NUM_BTN-1:0] frozen;
   logic               pair_ud;
   logic               pair_lr;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn_cell
      debounce_cell #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_cell (
         .clk   (clk),
         .rst   (rst),
         .raw   (btn_raw[i]),
         .level (btn_held[i]),
         .rise  (btn_rise[i]),
         .fall  (btn_fall[i])
      );
   end

   for (genvar i = 0; i < NUM_SW; i++) begin : g_sw_cell
      debounce_cell #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_cell (
         .clk   (clk),
         .rst   (rst),
         .raw   (sw_raw[i]),
         .level (sw_level[i]),
         .rise  (sw_rise_c[i]),
         .fall  (sw_fall_c[i])
      );
   end

   // Opposing directions held together are ambiguous, so both buttons of the pair stall
   assign pair_ud = btn_held[BTN_UP] & btn_held[BTN_DWN];
   assign pair_lr = btn_held[BTN_LF] & btn_held[BTN_RG];

   // Map each pair's conflict onto its two buttons; the pairs never affect each other
   always_comb begin
      frozen          = '0;
      frozen[BTN_UP]  = pair_ud;
      frozen[BTN_DWN] = pair_ud;
      frozen[BTN_LF]  = pair_lr;
      frozen[BTN_RG]  = pair_lr;
   end

   // Register the switch edge strobes so they appear the cycle after the level changes
   always_ff @(posedge clk) begin
      if (rst) begin
         sw_rise <= '0;
         sw_fall <= '0;
      end else begin
         sw_rise <= sw_rise_c;
         sw_fall <= sw_fall_c;
      end
   end

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn_fsm
      btn_state_t    state;
      logic [RW-1:0] rcnt;
      logic          pulse_q;

      // Press pulse, delayed first repeat, then periodic repeats; a stalled button keeps state and count untouched
      always_ff @(posedge clk) begin
         if (rst) begin
            state   <= IDLE;
            rcnt    <= '0;
            pulse_q <= 1'b0;
         end else begin
            pulse_q <= 1'b0;
            if (!frozen[i]) begin
               case (state)
                  IDLE: begin
                     if (btn_rise[i]) begin
                        pulse_q <= 1'b1;
                        state   <= DELAY;
                        rcnt    <= DELAY_LOAD;
                     end
                  end
                  DELAY, REPEAT: begin
                     // Release takes priority over an expiring count, so no pulse escapes on release
                     if (btn_fall[i]) begin
                        state <= IDLE;
                        rcnt  <= '0;
                     end else if (rcnt == '0) begin
                        pulse_q <= 1'b1;
                        state   <= REPEAT;
                        rcnt    <= RATE_LOAD;
                     end else begin
                        rcnt <= rcnt - RW'(1);
                     end
                  end
                  default: begin
                     state <= IDLE;
                     rcnt  <= '0;
                  end
               endcase
            end
         end
      end

      assign btn_pulse[i] = pulse_q;
   end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner against a behavioural reference model
module tb_button_conditioner;

   localparam int DEB = 4;
   localparam int RD  = 20;
   localparam int RR  = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] btn_raw = '0;
   logic [4:0] sw_raw = '0;
   logic [3:0] btn_pulse;
   logic [3:0] btn_held;
   logic [4:0] sw_level;
   logic [4:0] sw_rise;
   logic [4:0] sw_fall;

   int checks = 0;
   int errors = 0;

   logic [22:0] exp_q[$];

   // Reference model state: raw input history, accepted levels, per-button press age
   logic [8:0] hist [0:DEB+1];
   logic [8:0] acc   = '0;
   logic [8:0] acc_d = '0;
   bit         active [4];
   int         age    [4];

   always #5 clk = ~clk;

   button_conditioner #(
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_DELAY    (RD),
      .REPEAT_RATE     (RR)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw),
      .sw_raw    (sw_raw),
      .btn_pulse (btn_pulse),
      .btn_held  (btn_held),
      .sw_level  (sw_level),
      .sw_rise   (sw_rise),
      .sw_fall   (sw_fall)
   );

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   // One model step per clock edge, using the input values present at that edge
   task automatic model_step();
      logic [8:0]  nacc;
      logic [8:0]  rise;
      logic [8:0]  fall;
      logic [3:0]  pls;
      bit          flip;
      bit          stall;
      if (rst) begin
         for (int k = 0; k <= DEB + 1; k++) hist[k] = '0;
         acc   = '0;
         acc_d = '0;
         for (int b = 0; b < 4; b++) begin
            active[b] = 0;
            age[b]    = 0;
         end
         exp_q.push_back('0);
      end else begin
         for (int k = DEB + 1; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = {sw_raw, btn_raw};
         // An input's accepted level flips once the last DEB synchronised samples all disagree with it
         nacc = acc;
         for (int b = 0; b < 9; b++) begin
            flip = 1;
            for (int k = 2; k < DEB + 2; k++)
               if (hist[k][b] == acc[b]) flip = 0;
            if (flip) nacc[b] = ~acc[b];
         end
         rise = acc & ~acc_d;
         fall = ~acc & acc_d;
         pls  = '0;
         for (int b = 0; b < 4; b++) begin
            stall = acc[b] && acc[b ^ 1];
            if (!stall) begin
               if (rise[b]) begin
                  active[b] = 1;
                  age[b]    = 0;
                  pls[b]    = 1'b1;
               end else if (fall[b]) begin
                  active[b] = 0;
               end else if (active[b]) begin
                  age[b]++;
                  if (age[b] == RD || (age[b] > RD && (age[b] - RD) % RR == 0)) pls[b] = 1'b1;
               end
            end
         end
         exp_q.push_back({pls, nacc[3:0], nacc[8:4], rise[8:4], fall[8:4]});
         acc_d = acc;
         acc   = nacc;
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // Monitor: pop one expected output word per cycle and compare away from the active edge
   initial begin
      logic [22:0] e;
      logic [22:0] got;
      forever begin
         @(negedge clk);
         got = {btn_pulse, btn_held, sw_level, sw_rise, sw_fall};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_underflow: got %h, expected a queued word", got);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               errors++;
               $display("FAIL scoreboard t=%0t: got %h, expected %h", $time, got, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_held(input int idx, input logic val);
      int n = 0;
      while (btn_held[idx] !== val && n < 30) begin
         tick();
         n++;
      end
      check("wait_held", int'(btn_held[idx]), int'(val));
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   initial begin
      int npulse;
      int first;
      int second;
      int bad;
      int lat;
      int rise_at;
      int fall_at;
      int nrise;
      int nfall;
      int offs[$];
      int exp_off[7] = '{0, 20, 25, 30, 35, 40, 45};
      int len;

      rst = 1'b1;
      idle(3);
      check("reset_outputs", int'({btn_pulse, btn_held, sw_level, sw_rise, sw_fall}), 0);
      rst = 1'b0;
      idle(2);

      // Bounce on up, then a steady press
      npulse = 0;
      for (int k = 0; k < 12; k++) begin
         btn_raw[0] = ((k / 2) % 2) == 0;
         tick();
         npulse += int'(btn_pulse[0]);
      end
      btn_raw[0] = 1'b1;
      first = -1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (btn_pulse[0]) begin
            npulse++;
            if (first < 0) first = k;
         end
      end
      check("bounce_pulse_count", npulse, 1);
      check("bounce_latency", first, 7);
      btn_raw[0] = 1'b0;
      idle(15);

      // Auto-repeat on lf
      btn_raw[2] = 1'b1;
      wait_held(2, 1'b1);
      for (int k = 1; k <= 50; k++) begin
         tick();
         if (btn_pulse[2]) offs.push_back(k);
      end
      check("repeat_count", offs.size(), 7);
      if (offs.size() == 7) begin
         check("repeat_first", offs[0], 1);
         for (int j = 1; j < 7; j++) check("repeat_offset", offs[j] - offs[0], exp_off[j]);
      end
      btn_raw[2] = 1'b0;
      wait_held(2, 1'b0);
      npulse = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         npulse += int'(btn_pulse[2]);
      end
      check("release_no_pulse", npulse, 0);
      idle(5);

      // up/dwn conflict
      btn_raw[0] = 1'b1;
      wait_held(0, 1'b1);
      idle(3);
      btn_raw[1] = 1'b1;
      wait_held(1, 1'b1);
      bad = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (btn_held[0] && btn_held[1]) bad += int'(btn_pulse[0]) + int'(btn_pulse[1]);
      end
      btn_raw[1] = 1'b0;
      for (int k = 0; k < 30 && btn_held[1]; k++) begin
         tick();
         if (btn_held[0] && btn_held[1]) bad += int'(btn_pulse[0]) + int'(btn_pulse[1]);
      end
      check("conflict_no_pulse", bad, 0);
      check("conflict_release", int'(btn_held[1]), 0);
      first = -1;
      for (int k = 1; k <= 25; k++) begin
         tick();
         if (btn_pulse[0] && first < 0) first = k;
      end
      check("conflict_resume_offset", first, 12);
      btn_raw[0] = 1'b0;
      idle(15);

      // Switch edges on format
      sw_raw[4] = 1'b1;
      lat = -1; rise_at = -1; fall_at = -1; nrise = 0; nfall = 0;
      for (int k = 1; k <= 35; k++) begin
         tick();
         if (k == 10) sw_raw[4] = 1'b0;
         if (sw_level[4] && lat < 0) lat = k;
         if (sw_rise[4]) begin nrise++; rise_at = k; end
         if (sw_fall[4]) begin nfall++; fall_at = k; end
      end
      check("sw_level_latency", lat, 6);
      check("sw_rise_count", nrise, 1);
      check("sw_rise_cycle", rise_at, 7);
      check("sw_fall_count", nfall, 1);
      check("sw_fall_cycle", fall_at, 17);
      idle(5);

      // Reset while rg is repeating
      btn_raw[3] = 1'b1;
      wait_held(3, 1'b1);
      idle(30);
      rst = 1'b1;
      tick();
      check("reset_mid_hold", int'({btn_pulse, btn_held, sw_level, sw_rise, sw_fall}), 0);
      rst = 1'b0;
      first = -1; second = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (btn_pulse[3]) begin
            if (first < 0) first = k;
            else if (second < 0) second = k;
         end
      end
      check("reset_first_pulse", first, 7);
      check("reset_first_repeat", second, 27);
      btn_raw[3] = 1'b0;
      idle(15);

      // Short glitch on fecha
      sw_raw[1] = 1'b1;
      idle(3);
      sw_raw[1] = 1'b0;
      bad = 0;
      for (int k = 0; k < 15; k++) begin
         tick();
         bad += int'(sw_level[1]) + int'(sw_rise[1]) + int'(sw_fall[1]);
      end
      check("glitch_rejected", bad, 0);

      // Randomised segments, scoreboard only
      for (int seg = 0; seg < 60; seg++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 2) == 0) btn_raw[b] = ~btn_raw[b];
         for (int b = 0; b < 5; b++)
            if ($urandom_range(0, 2) == 0) sw_raw[b] = ~sw_raw[b];
         if ($urandom_range(0, 29) == 0) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
         end
         len = $urandom_range(1, 45);
         idle(len);
      end

      btn_raw = '0;
      sw_raw  = '0;
      idle(20);
      @(negedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Input front end of the RTC controller. It conditions the raw push-buttons (up, down, left, right) and slide switches (hora, fecha, crono, iniC, format) that the controller consumes. Each input is synchronised and debounced. Buttons produce single-cycle pulses with auto-repeat, and switches produce clean levels plus edge strobes. The block replaces raw board pins at the controller's `up/dwn/lf/rg/SW*` inputs.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: number of consecutive stable cycles required to accept a new input level.
- `REPEAT_DELAY`, default 50_000_000: cycles from the first button pulse to the first repeat pulse.
- `REPEAT_RATE`, default 10_000_000: cycles between subsequent repeat pulses.
- `clk  in  1`: system clock; only clock.
- `rst  in  1`: reset; synchronous, active-high.
- `btn_raw  in  4`: raw buttons, [0]=up, [1]=dwn, [2]=lf, [3]=rg; asynchronous; 1 = pressed.
- `sw_raw  in  5`: raw switches, [0]=hora, [1]=fecha, [2]=crono, [3]=iniC, [4]=format; asynchronous.
- `btn_pulse  out  4`: one-cycle press/repeat strobes, same bit order as `btn_raw`.
- `btn_held  out  4`: debounced button levels.
- `sw_level  out  5`: debounced switch levels.
- `sw_rise  out  5`: one-cycle strobe on a debounced 0→1 switch transition.
- `sw_fall  out  5`: one-cycle strobe on a debounced 1→0 switch transition.

## Operation
- **Every input:** 2-FF synchroniser, then a debounce counter.
  - Counter clears whenever the synchronised value equals the accepted level.
  - Otherwise it increments. On reaching `DEBOUNCE_CYCLES-1`, the accepted level takes the synchronised value and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes the accepted level.
- **Per-button FSM:**
  - IDLE: accepted level rises → emit 1 pulse, go to DELAY, load repeat counter with `REPEAT_DELAY-1`.
  - DELAY: counter reaches 0 → emit pulse, go to REPEAT, load `REPEAT_RATE-1`.
  - REPEAT: counter reaches 0 → emit pulse, reload `REPEAT_RATE-1`.
  - DELAY or REPEAT: accepted level falls → IDLE immediately, no pulse.
- **up/dwn conflict:** while `btn_held[0]` and `btn_held[1]` are both 1, suppress the pulses of both and hold both FSMs in their current state with counters frozen. Same rule for lf/rg (bits 2/3). Pairs are independent of each other.
- **Switches:** `sw_rise` / `sw_fall` assert for exactly the cycle after `sw_level` changes. Switches never auto-repeat.
- **Counter widths:** `$clog2(param+1)`. Repeat counter is shared per button; there is no wrap beyond reload.

## Timing
- **Reset values:** all outputs 0; synchronisers, accepted levels and counters 0; FSMs IDLE.
- A button held across reset release is treated as a fresh press: one pulse after debounce.
- **Latency, raw edge to accepted-level change:** 2 sync cycles + `DEBOUNCE_CYCLES` cycles.
- **Pulse timing:** `btn_pulse` is registered and asserts in the cycle after `btn_held` rises.
- **Repeat spacing:** first repeat `REPEAT_DELAY` cycles after the first pulse; subsequent repeats every `REPEAT_RATE` cycles.
- **Release:** a release seen in the same cycle a repeat counter expires wins, so no pulse is emitted.
- **Reset mid-hold:** outputs drop to 0 in the cycle after `rst`; no partial pulse is emitted.

## Structure
- **Shared package `rtc_ui_pkg`:**
  - index constants `BTN_UP=0`, `BTN_DWN=1`, `BTN_LF=2`, `BTN_RG=3`;
  - index constants `SW_HORA=0`, `SW_FECHA=1`, `SW_CRONO=2`, `SW_INIC=3`, `SW_FMT=4`;
  - FSM state enum `{IDLE, DELAY, REPEAT}`.
- **Sub-module `debounce_cell`** (synchroniser + debounce counter + accepted level + edge strobes). It is instantiated 9 times.
- The button FSMs and the conflict logic live in the top level.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES=4`, `REPEAT_DELAY=20`, `REPEAT_RATE=5`.
1. **Bounce:** `btn_raw[0]` toggles every 2 cycles for 12 cycles, then holds 1 → exactly one `btn_pulse[0]`, 7 cycles after the final rise (2 sync + 4 debounce + 1); no pulse during bouncing.
2. **Auto-repeat:** hold `btn_raw[2]` for 50 cycles after acceptance → pulses at offsets 0, 20, 25, 30, 35, 40, 45; release → no further pulses, FSM returns to IDLE.
3. **Conflict:** accept up, then press dwn 3 cycles later and hold both for 40 cycles → after `btn_held[1]` rises, no `btn_pulse[1:0]`. Release dwn → up resumes repeats with its counter unfrozen.
4. **Switch edges:** `sw_raw[4]` 0→1, held 10 cycles, then 1→0 → `sw_level[4]` follows after 6 cycles; one `sw_rise[4]` and one `sw_fall[4]` strobe, each 1 cycle.
5. **Reset mid-hold:** `rst` asserted for 1 cycle during REPEAT with the button still held → all outputs 0 the next cycle; the button is re-debounced and produces a new first pulse, followed by a repeat 20 cycles later.
6. **Glitch rejection:** a 3-cycle pulse on `sw_raw[1]` → `sw_level[1]` stays 0 and no strobes are emitted.
